// File: rtl/seven_seg_if.sv
// Bundle between the value producer and the seven-segment scanner:
// digit nibbles, decimal points and control strobes in, segment/anode drive out.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic                    load;
    logic                    enable;
    logic                    lz_en;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits, dp_en, load, enable, lz_en,
        input  seg, an
    );

    modport slave (
        input  digits, dp_en, load, enable, lz_en,
        output seg, an
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: shadow-buffered hex digits,
// per-digit decimal points, leading-zero blanking, anti-ghost gap, selectable polarity.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    seven_seg_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic             INV     = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]        div_cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [7:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   suppress;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    blank_done;
    logic                    active;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are
    // zero; a lit decimal point keeps it visible. Digit 0 always shows.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi]    = shadow_digits_reg[4*gi +: 4];
        assign onehot[gi] = (idx_reg == IDX_W'(gi));
        if (gi == 0) begin : g_lsd
            assign suppress[gi] = 1'b0;
        end else begin : g_upper
            assign suppress[gi] = bus.lz_en && !shadow_dp_reg[gi]
                && (shadow_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    if (BLANK_CYCLES == 0) begin : g_noblank
        assign blank_done = 1'b1;
    end else begin : g_blank
        assign blank_done = (div_cnt_reg >= DIV_W'(BLANK_CYCLES));
    end

    assign active = bus.enable && blank_done && !suppress[idx_reg];

    always_comb begin
        seg_next = {8{INV}};
        an_next  = {NUM_DIGITS{INV}};
        if (active) begin
            seg_next = {shadow_dp_reg[idx_reg], hex7(nib[idx_reg])} ^ {8{INV}};
            an_next  = onehot ^ {NUM_DIGITS{INV}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg       <= '0;
            idx_reg           <= '0;
            shadow_digits_reg <= '0;
            shadow_dp_reg     <= '0;
            seg_reg           <= {8{INV}};
            an_reg            <= {NUM_DIGITS{INV}};
        end else begin
            if (div_cnt_reg == DIV_MAX) begin
                div_cnt_reg <= '0;
                idx_reg     <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
            if (bus.load) begin
                shadow_digits_reg <= bus.digits;
                shadow_dp_reg     <= bus.dp_en;
            end
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg = seg_reg;
    assign bus.an  = an_reg;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed plus randomized bench for seven_seg_scan; an active-low and an
// active-high instance share stimulus and are checked every cycle against a model.
module tb_seven_seg_scan;
    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_if #(.NUM_DIGITS(ND)) bus ();
    seven_seg_if #(.NUM_DIGITS(ND)) bus_hi ();

    assign bus_hi.digits = bus.digits;
    assign bus_hi.dp_en  = bus.dp_en;
    assign bus_hi.load   = bus.load;
    assign bus_hi.enable = bus.enable;
    assign bus_hi.lz_en  = bus.lz_en;

    seven_seg_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    seven_seg_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .bus(bus_hi.slave)
    );

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges since reset release plus the buffered display value.
    int              n;
    logic [4*ND-1:0] sh_dig;
    logic [ND-1:0]   sh_dp;
    int              checks = 0;
    int              errors = 0;

    task automatic tick();
        logic [7:0]    es;
        logic [ND-1:0] ea;
        int            slot_pos, ix;
        logic [3:0]    v;
        logic          sup;
        es = '0;
        ea = '0;
        if (rst_n) begin
            slot_pos = n % CD;
            ix       = (n / CD) % ND;
            v        = 4'((sh_dig >> (4 * ix)) & 16'hF);
            sup      = bus.lz_en && (ix > 0) && ((sh_dig >> (4 * ix)) == 0) && !sh_dp[ix];
            if (bus.enable && slot_pos >= BC && !sup) begin
                es = {sh_dp[ix], hex_tab[v]};
                ea = ND'(1) << ix;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            n      = 0;
            sh_dig = '0;
            sh_dp  = '0;
        end else begin
            n++;
            if (bus.load) begin
                sh_dig = bus.digits;
                sh_dp  = bus.dp_en;
            end
        end
        #1;
        checks++;
        assert (bus.seg === ~es) else begin
            errors++;
            $error("FAIL seg_lo: got %h expected %h (t=%0t)", bus.seg, ~es, $time);
        end
        checks++;
        assert (bus.an === ~ea) else begin
            errors++;
            $error("FAIL an_lo: got %b expected %b (t=%0t)", bus.an, ~ea, $time);
        end
        checks++;
        assert (bus_hi.seg === es) else begin
            errors++;
            $error("FAIL seg_hi: got %h expected %h (t=%0t)", bus_hi.seg, es, $time);
        end
        checks++;
        assert (bus_hi.an === ea) else begin
            errors++;
            $error("FAIL an_hi: got %b expected %b (t=%0t)", bus_hi.an, ea, $time);
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] dp);
        bus.digits = d;
        bus.dp_en  = dp;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    initial begin
        n           = 0;
        sh_dig      = '0;
        sh_dp       = '0;
        rst_n       = 1'b0;
        bus.digits  = '0;
        bus.dp_en   = '0;
        bus.load    = 1'b0;
        bus.enable  = 1'b1;
        bus.lz_en   = 1'b0;
        #1;
        run(3);

        // Basic scan with 1234, then hex letters with a decimal point
        rst_n = 1'b1;
        load_val(16'h1234, 4'b0000);
        run(33);
        load_val(16'hABCD, 4'b0010);
        run(16);

        // Leading-zero suppression
        bus.lz_en = 1'b1;
        load_val(16'h0070, 4'b0000);
        run(16);
        load_val(16'h0000, 4'b0000);
        run(16);
        load_val(16'h0305, 4'b0100);
        run(16);
        bus.lz_en = 1'b0;
        run(16);

        // Inputs change without load, then a mid-slot load
        bus.digits = 16'h9876;
        run(10);
        load_val(16'h9876, 4'b1001);
        run(9);

        // Gating keeps the scan running
        bus.enable = 1'b0;
        run(10);
        bus.enable = 1'b1;
        run(10);

        // Reset mid-scan
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        load_val(16'h0008, 4'b0000);
        run(16);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bus.digits = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            bus.dp_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.load   = ($urandom_range(0, 5) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bus.lz_en = ~bus.lz_en;
            rst_n      = ($urandom_range(0, 99) != 0);
            tick();
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
